// File: rtl/comp16_argmax_seq.sv
// Streaming argmax engine that time-multiplexes one COMP16 greater-than comparator.
// Beats are registered in stage 1 and compared against the running maximum in stage 2.

module comp16 (
    input  logic [15:0] x_a_i,
    input  logic [15:0] x_b_i,
    output logic        wx_o
);
    assign wx_o = (x_a_i > x_b_i);
endmodule

// state | meaning
// IDLE  | waiting for the first beat of a stream
// RUN   | accepting beats, comparing the previous one
// FLUSH | last beat sits in stage 1, final compare this cycle
// DONE  | result presented, waiting for out_ready_i
module comp16_argmax_seq #(
    parameter int IDX_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               sync_clr_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [15:0]        in_data_i,
    input  logic               in_last_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [15:0]        out_max_o,
    output logic [IDX_W-1:0]   out_idx_o,
    output logic [IDX_W:0]     out_len_o,
    output logic               out_ovf_o
);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               s_valid_q, s_valid_d;
    logic [15:0]        s_data_q, s_data_d;
    logic [IDX_W-1:0]   s_idx_q, s_idx_d;
    logic               s_last_q, s_last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        max_q, max_d;
    logic [IDX_W-1:0]   max_idx_q, max_idx_d;
    logic               max_vld_q, max_vld_d;
    logic [15:0]        out_max_q, out_max_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic [CNT_W-1:0]   out_len_q, out_len_d;
    logic               out_ovf_q, out_ovf_d;

    logic               wx;
    logic               accept;
    logic               take;
    logic               capture;

    comp16 u_comp16 (
        .x_a_i (s_data_q),
        .x_b_i (max_q),
        .wx_o  (wx)
    );

    // Reset gates in_ready_o directly so it reads low for the whole reset pulse.
    assign in_ready_o  = ((state_q == S_IDLE) || (state_q == S_RUN)) && !rst_i;
    assign out_valid_o = (state_q == S_DONE);
    assign out_max_o   = out_max_q;
    assign out_idx_o   = out_idx_q;
    assign out_len_o   = out_len_q;
    assign out_ovf_o   = out_ovf_q;

    always_comb begin
        state_d   = state_q;
        accept    = in_valid_i && in_ready_o && !sync_clr_i;
        take      = s_valid_q && (!max_vld_q || wx);
        capture   = 1'b0;

        s_valid_d = accept;
        s_data_d  = s_data_q;
        s_idx_d   = s_idx_q;
        s_last_d  = s_last_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;

        max_d     = take ? s_data_q : max_q;
        max_idx_d = take ? s_idx_q : max_idx_q;
        max_vld_d = max_vld_q || s_valid_q;

        if (accept) begin
            s_data_d = in_data_i;
            s_last_d = in_last_i;
            // Indices past the representable range all collapse onto the top index.
            s_idx_d  = cnt_q[IDX_W] ? {IDX_W{1'b1}} : cnt_q[IDX_W-1:0];
            ovf_d    = ovf_q || cnt_q[IDX_W];
            cnt_d    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (accept) state_d = in_last_i ? S_FLUSH : S_RUN;
            end
            S_RUN: begin
                if (accept && in_last_i) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (s_valid_q && s_last_q) begin
                    state_d = S_DONE;
                    capture = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d   = S_IDLE;
                    max_vld_d = 1'b0;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (sync_clr_i) begin
            state_d   = S_IDLE;
            s_valid_d = 1'b0;
            max_vld_d = 1'b0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            capture   = 1'b0;
        end

        out_max_d = capture ? max_d     : out_max_q;
        out_idx_d = capture ? max_idx_d : out_idx_q;
        out_len_d = capture ? cnt_d     : out_len_q;
        out_ovf_d = capture ? ovf_d     : out_ovf_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_idx_q   <= '0;
            s_last_q  <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            max_q     <= '0;
            max_idx_q <= '0;
            max_vld_q <= 1'b0;
            out_max_q <= '0;
            out_idx_q <= '0;
            out_len_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            s_idx_q   <= s_idx_d;
            s_last_q  <= s_last_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
            max_vld_q <= max_vld_d;
            out_max_q <= out_max_d;
            out_idx_q <= out_idx_d;
            out_len_q <= out_len_d;
            out_ovf_q <= out_ovf_d;
        end
    end
endmodule

// File: tb/tb_comp16_argmax_seq.sv
// Bench for comp16_argmax_seq: IDX_W=8 and IDX_W=2 instances share one stimulus stream.
// Directed table, multi-cycle corner sequences, then random streams against a queue model.

module tb_comp16_argmax_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sync_clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        rdy8, ov8, ovf8;
    logic [15:0] max8;
    logic [7:0]  idx8;
    logic [8:0]  len8;
    logic        rdy2, ov2, ovf2;
    logic [15:0] max2;
    logic [1:0]  idx2;
    logic [2:0]  len2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    comp16_argmax_seq #(.IDX_W(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .sync_clr_i(sync_clr),
        .in_valid_i(in_valid), .in_ready_o(rdy8), .in_data_i(in_data), .in_last_i(in_last),
        .out_valid_o(ov8), .out_ready_i(out_ready),
        .out_max_o(max8), .out_idx_o(idx8), .out_len_o(len8), .out_ovf_o(ovf8)
    );

    comp16_argmax_seq #(.IDX_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .sync_clr_i(sync_clr),
        .in_valid_i(in_valid), .in_ready_o(rdy2), .in_data_i(in_data), .in_last_i(in_last),
        .out_valid_o(ov2), .out_ready_i(out_ready),
        .out_max_o(max2), .out_idx_o(idx2), .out_len_o(len2), .out_ovf_o(ovf2)
    );

    typedef struct {
        int n;
        int v[8];
        int emax;
        int eidx8;
        int elen8;
        int eidx2;
        int elen2;
        int eovf2;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Returns just after the accepting edge; stalls counts cycles spent with in_ready low.
    task automatic send_beat(input int d, input bit last, output int stalls);
        bit done;
        done = 1'b0;
        stalls = 0;
        in_valid = 1'b1;
        in_data = 16'(d);
        in_last = last;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (rdy8) done = 1'b1;
            else stalls++;
            @(posedge clk);
            #1;
        end
        if (!done) chk("beat_timeout", 0, 1);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_stream(input int q[$], input bit gaps, output int stalls_total);
        int s;
        stalls_total = 0;
        for (int j = 0; j < q.size(); j++) begin
            send_beat(q[j], (j == q.size() - 1), s);
            stalls_total += s;
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Returns at a falling edge with out_valid high, or after a counted timeout.
    task automatic wait_result();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            if (ov8) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) chk("result_timeout", 0, 1);
    endtask

    task automatic check_result(input string tg, input int emax, input int eidx8, input int elen8,
                                input int eovf8, input int eidx2, input int elen2, input int eovf2);
        chk({tg, "_valid8"}, ov8, 1);
        chk({tg, "_valid2"}, ov2, 1);
        chk({tg, "_max8"}, max8, emax);
        chk({tg, "_idx8"}, idx8, eidx8);
        chk({tg, "_len8"}, len8, elen8);
        chk({tg, "_ovf8"}, ovf8, eovf8);
        chk({tg, "_max2"}, max2, emax);
        chk({tg, "_idx2"}, idx2, eidx2);
        chk({tg, "_len2"}, len2, elen2);
        chk({tg, "_ovf2"}, ovf2, eovf2);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("pop_valid_low", ov8, 0);
        chk("pop_ready_high", rdy8, 1);
    endtask

    function automatic void model(input int q[$], input int w, output int mx, output int idx,
                                  output int len, output int ovf);
        int top;
        mx = -1;
        idx = 0;
        foreach (q[i]) if (q[i] > mx) begin mx = q[i]; idx = i; end
        top = (1 << w) - 1;
        if (idx > top) idx = top;
        len = (q.size() > (1 << (w + 1)) - 1) ? (1 << (w + 1)) - 1 : q.size();
        ovf = (q.size() > (1 << w)) ? 1 : 0;
    endfunction

    initial begin
        int q[$];
        int st;
        int m8, i8, l8, o8, m2, i2, l2, o2, mode, n;

        tbl[0] = '{3, '{5, 9, 3, 0, 0, 0, 0, 0}, 9, 1, 3, 1, 3, 0};
        tbl[1] = '{1, '{'h1234, 0, 0, 0, 0, 0, 0, 0}, 'h1234, 0, 1, 0, 1, 0};
        tbl[2] = '{3, '{7, 7, 7, 0, 0, 0, 0, 0}, 7, 0, 3, 0, 3, 0};
        tbl[3] = '{3, '{'h7FFF, 'hFFFF, 'h8000, 0, 0, 0, 0, 0}, 'hFFFF, 1, 3, 1, 3, 0};
        tbl[4] = '{6, '{1, 2, 3, 4, 5, 6, 0, 0}, 6, 5, 6, 3, 6, 1};
        tbl[5] = '{5, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 0, 5, 0, 5, 1};
        tbl[6] = '{8, '{1, 2, 3, 4, 5, 6, 7, 8}, 8, 7, 8, 3, 7, 1};

        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", rdy8, 0);
        chk("rst_out_valid", ov8, 0);
        chk("rst_out_max", max8, 0);
        chk("rst_out_len", len8, 0);
        chk("rst_out_ovf2", ovf2, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", rdy8, 1);
        @(posedge clk);
        #1;

        // Directed table with latency and no-bubble checks.
        for (int i = 0; i < 7; i++) begin
            q.delete();
            for (int j = 0; j < tbl[i].n; j++) q.push_back(tbl[i].v[j]);
            send_stream(q, 1'b0, st);
            chk($sformatf("t%0d_no_bubble", i), st, 0);
            @(negedge clk);
            chk($sformatf("t%0d_lat_k1", i), ov8, 0);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("t%0d_lat_k2", i), ov8, 1);
            check_result($sformatf("t%0d", i), tbl[i].emax, tbl[i].eidx8, tbl[i].elen8, 0,
                         tbl[i].eidx2, tbl[i].elen2, tbl[i].eovf2);
            pop();
            @(posedge clk);
            #1;
        end

        // Back-pressure: result held while a new beat waits on the input.
        q = '{3, 1};
        send_stream(q, 1'b0, st);
        wait_result();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data = 16'h0055;
        in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_in_ready", rdy8, 0);
            chk("bp_out_valid", ov8, 1);
            chk("bp_out_max", max8, 3);
            chk("bp_out_len", len8, 2);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready_after_pop", rdy8, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        wait_result();
        check_result("bp_next", 'h55, 0, 1, 0, 0, 1, 0);
        pop();

        // Asynchronous reset mid-stream.
        @(posedge clk);
        #1;
        send_beat(10, 1'b0, st);
        send_beat(20, 1'b0, st);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", rdy8, 0);
        chk("mid_rst_out_valid", ov8, 0);
        chk("mid_rst_out_max", max8, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        q = '{8, 2};
        send_stream(q, 1'b0, st);
        wait_result();
        check_result("rst_fresh", 8, 0, 2, 0, 0, 2, 0);
        pop();

        // sync_clr mid-stream wins over a simultaneous last beat.
        @(posedge clk);
        #1;
        send_beat(10, 1'b0, st);
        send_beat(20, 1'b0, st);
        sync_clr = 1'b1;
        in_valid = 1'b1;
        in_data = 16'hFFFF;
        in_last = 1'b1;
        @(posedge clk);
        #1;
        sync_clr = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("clr_no_result", ov8, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("clr_ready", rdy8, 1);
        chk("clr_keeps_max", max8, 8);
        chk("clr_keeps_len", len8, 2);
        @(posedge clk);
        #1;
        q = '{4, 6};
        send_stream(q, 1'b0, st);
        wait_result();
        check_result("clr_fresh", 6, 1, 2, 0, 1, 2, 0);
        pop();

        // Random streams against the queue model.
        for (int r = 0; r < 30; r++) begin
            q.delete();
            n = $urandom_range(1, 12);
            mode = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) begin
                case (mode)
                    0: q.push_back($urandom_range(0, 65535));
                    1: q.push_back($urandom_range(0, 3));
                    default: q.push_back($urandom_range(65532, 65535));
                endcase
            end
            model(q, 8, m8, i8, l8, o8);
            model(q, 2, m2, i2, l2, o2);
            @(posedge clk);
            #1;
            send_stream(q, 1'b1, st);
            wait_result();
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            check_result($sformatf("rnd%0d", r), m8, i8, l8, o8, i2, l2, o2);
            chk($sformatf("rnd%0d_max2_model", r), max2, m2);
            pop();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
